// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl
//   Direct-mapped, write-through, no-write-allocate data cache controller
//   between the MEM stage and a multi-cycle backing data memory. Lines are
//   one 32-bit word. A read hit returns data in the same cycle. A read miss
//   or any store freezes the pipeline through `stall` until the backing
//   memory acknowledges, followed by one response cycle in which the
//   pipeline advances.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   cpu_read/cpu_write      load / store request (store wins if both set)
//   cpu_sb                  store is a byte store
//   cpu_addr, cpu_wdata     byte address and store data from EX/MEM
//   cpu_rdata               load data to MEM/WB
//   stall                   freeze the pipeline this cycle
//   mem_req/we/sb/addr/wdata  backing-memory request, stable until mem_ready
//   mem_rdata, mem_ready    backing-memory read data and one-cycle acknowledge
//   hit_count, miss_count   saturating read hit / read miss counters
module data_cache_ctrl #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic        cpu_sb,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Counter increment that sticks at the all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    // Replace one byte lane of a word with a store byte.
    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [7:0]  b,
                                               input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r        = word;
        endcase
        return r;
    endfunction

    state_t             state_r;
    logic [LINES-1:0]   valid_r;
    logic [TAG_W-1:0]   tag_r [LINES];
    logic [31:0]        data_r [LINES];
    logic [31:0]        rdata_r;
    logic [31:0]        hit_cnt_r;
    logic [31:0]        miss_cnt_r;
    logic               mem_req_r;
    logic               mem_we_r;
    logic               mem_sb_r;
    logic [31:0]        mem_addr_r;
    logic [31:0]        mem_wdata_r;

    logic [INDEX_W-1:0] index_s;
    logic [TAG_W-1:0]   tag_s;
    logic [31:0]        word_addr_s;
    logic               hit_s;
    logic               fill_s;
    logic               store_s;
    logic               stall_s;
    logic [31:0]        rdata_s;

    assign index_s     = cpu_addr[INDEX_W+1:2];
    assign tag_s       = cpu_addr[31:INDEX_W+2];
    assign word_addr_s = {cpu_addr[31:2], 2'b00};
    assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
    // Inputs are frozen during the wait states, so index/tag still name the
    // line that the outstanding transaction belongs to.
    assign fill_s      = (state_r == RD_WAIT) && mem_ready;
    assign store_s     = (state_r == WR_WAIT) && mem_ready && hit_s;

    // Stall and load-data selection; a read hit bypasses the response register.
    always_comb begin
        stall_s = 1'b0;
        rdata_s = rdata_r;
        case (state_r)
            IDLE: begin
                if (cpu_write) begin
                    stall_s = 1'b1;
                end else if (cpu_read) begin
                    if (hit_s) begin
                        rdata_s = data_r[index_s];
                    end else begin
                        stall_s = 1'b1;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            RD_WAIT: stall_s = 1'b1;
            WR_WAIT: stall_s = 1'b1;
            RESP:    stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // A request held on the inputs while reset is low must not freeze the pipe.
    assign stall      = stall_s & reset;
    assign cpu_rdata  = rdata_s;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_sb     = mem_sb_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign hit_count  = hit_cnt_r;
    assign miss_count = miss_cnt_r;

    // Line storage: refill on read completion, in-place update on a store hit.
    always_ff @(posedge clock) begin
        if (fill_s) begin
            data_r[index_s] <= mem_rdata;
            tag_r[index_s]  <= tag_s;
        end else if (store_s) begin
            data_r[index_s] <= cpu_sb ? merge_byte(data_r[index_s], cpu_wdata[7:0], cpu_addr[1:0])
                                      : cpu_wdata;
        end
    end

    // Controller FSM with valid bits, counters and the memory request registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            valid_r     <= '0;
            rdata_r     <= 32'd0;
            hit_cnt_r   <= 32'd0;
            miss_cnt_r  <= 32'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_sb_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_write) begin
                        state_r     <= WR_WAIT;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_sb_r    <= cpu_sb;
                        mem_addr_r  <= cpu_sb ? cpu_addr : word_addr_s;
                        mem_wdata_r <= cpu_wdata;
                    end else if (cpu_read) begin
                        if (hit_s) begin
                            hit_cnt_r <= sat_inc(hit_cnt_r);
                            rdata_r   <= data_r[index_s];
                        end else begin
                            miss_cnt_r <= sat_inc(miss_cnt_r);
                            state_r    <= RD_WAIT;
                            mem_req_r  <= 1'b1;
                            mem_we_r   <= 1'b0;
                            mem_sb_r   <= 1'b0;
                            mem_addr_r <= word_addr_s;
                        end
                    end
                end
                RD_WAIT: begin
                    if (mem_ready) begin
                        valid_r[index_s] <= 1'b1;
                        rdata_r          <= mem_rdata;
                        mem_req_r        <= 1'b0;
                        state_r          <= RESP;
                    end
                end
                WR_WAIT: begin
                    if (mem_ready) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        mem_sb_r  <= 1'b0;
                        state_r   <= RESP;
                    end
                end
                // The request still on the inputs was already served; let the pipe advance.
                RESP:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: directed scenarios with literal
// expectations, then randomized loads/stores checked each cycle against a
// transaction-level model of the cache lines and the backing memory.
module tb_data_cache_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write, cpu_sb;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall, mem_req, mem_we, mem_sb, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;

    data_cache_ctrl dut (
        .clock(clock), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_sb(cpu_sb),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_sb(mem_sb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cyc = 0;

    // Expected outputs for the current cycle.
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0, exp_sb = 1'b0;
    logic [31:0] exp_rdata = 32'd0, exp_addr = 32'd0, exp_wdata = 32'd0;
    logic [31:0] exp_hits = 32'd0, exp_misses = 32'd0;
    bit          pend_hit = 0, pend_miss = 0;

    // Model: which word address each line holds, its data, and memory contents.
    logic [31:0] mdl_addr [16];
    bit          mdl_ok   [16];
    logic [31:0] mdl_data [16];
    logic [31:0] mem_model [logic [31:0]];

    // Memory responder controls.
    int          lat = 1;
    int          rcnt = 0;
    bit          force_ready = 0;
    logic [31:0] force_data = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (mem_model.exists(wa)) return mem_model[wa];
        return (wa * 32'h9E37_79B1) + 32'h0000_1357;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [7:0] b,
                                             input logic [1:0] lane);
        int sh;
        sh = 8 * int'(lane);
        return (w & ~(32'hFF << sh)) | ({24'd0, b} << sh);
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clock) begin
        if (stall === 1'b1) stall_cyc++;
        if (chk_en) begin
            chk("stall", stall, exp_stall);
            chk("cpu_rdata", cpu_rdata, exp_rdata);
            chk("mem_req", mem_req, exp_req);
            if (exp_req) begin
                chk("mem_we", mem_we, exp_we);
                chk("mem_sb", mem_sb, exp_sb);
                chk("mem_addr", mem_addr, exp_addr);
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
            chk("hit_count", hit_count, exp_hits);
            chk("miss_count", miss_count, exp_misses);
        end
    end

    // Backing memory: acknowledge on the lat-th cycle mem_req is seen high.
    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            rcnt = 0;
            mem_ready = 1'b0;
        end else if (force_ready) begin
            mem_ready = 1'b1;
            mem_rdata = force_data;
        end else if (mem_req === 1'b1) begin
            rcnt++;
            if (rcnt == lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_word({mem_addr[31:2], 2'b00});
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0_0000 | rcnt;
            end
        end else begin
            rcnt = 0;
            mem_ready = 1'b0;
        end
    end

    // Advance one cycle; counter updates from the previous cycle become visible.
    task automatic cyc();
        @(posedge clock);
        #1;
        if (pend_hit)  exp_hits   = sat(exp_hits);
        if (pend_miss) exp_misses = sat(exp_misses);
        pend_hit  = 0;
        pend_miss = 0;
    endtask

    // One pipeline access, from its first cycle through its response cycle.
    task automatic access(input bit rd, input bit wr, input bit sb,
                          input logic [31:0] addr, input logic [31:0] wdata, input int n);
        logic [31:0] wa, nw;
        int idx;
        bit hit;
        wa  = {addr[31:2], 2'b00};
        idx = int'((addr >> 2) & 32'hF);
        hit = mdl_ok[idx] && (mdl_addr[idx] == wa);
        cyc();
        lat = n;
        cpu_read = rd; cpu_write = wr; cpu_sb = sb; cpu_addr = addr; cpu_wdata = wdata;
        exp_req = 1'b0;
        if (wr) begin
            exp_stall = 1'b1;
            cyc();
            exp_req = 1'b1; exp_we = 1'b1; exp_sb = sb;
            exp_addr = sb ? addr : wa; exp_wdata = wdata;
            for (int k = 1; k < n; k++) cyc();
            cyc();
            exp_stall = 1'b0; exp_req = 1'b0;
            nw = sb ? put_byte(mem_word(wa), wdata[7:0], addr[1:0]) : wdata;
            mem_model[wa] = nw;
            if (hit) mdl_data[idx] = nw;
        end else if (rd) begin
            if (hit) begin
                exp_stall = 1'b0;
                exp_rdata = mdl_data[idx];
                pend_hit  = 1;
            end else begin
                exp_stall = 1'b1;
                pend_miss = 1;
                cyc();
                exp_req = 1'b1; exp_we = 1'b0; exp_sb = 1'b0; exp_addr = wa;
                for (int k = 1; k < n; k++) cyc();
                cyc();
                exp_stall = 1'b0; exp_req = 1'b0;
                exp_rdata = mem_word(wa);
                mdl_ok[idx] = 1; mdl_addr[idx] = wa; mdl_data[idx] = exp_rdata;
            end
        end else begin
            exp_stall = 1'b0;
        end
    endtask

    initial begin
        int s0;
        logic [25:0] tg;
        logic [31:0] ra;
        int kind;
        reset = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_sb = 1'b0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        for (int i = 0; i < 16; i++) begin
            mdl_ok[i] = 0; mdl_addr[i] = 32'd0; mdl_data[i] = 32'd0;
        end
        mem_model[32'h40] = 32'hDEADBEEF;
        chk_en = 1'b1;

        // Reset state.
        @(negedge clock);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_sb", mem_sb, 1'b0);
        cyc();
        cyc();
        reset = 1'b1;

        // Cold read, latency 3: four stall cycles, data in the response cycle.
        s0 = stall_cyc;
        access(1, 0, 0, 32'h40, 32'd0, 3);
        @(negedge clock);
        chk("pin_cold_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("pin_cold_stall_cycles", stall_cyc - s0, 4);
        chk("pin_cold_miss", miss_count, 32'd1);

        // Repeat read hits with no stall.
        access(1, 0, 0, 32'h40, 32'd0, 1);
        @(negedge clock);
        chk("pin_hit_stall", stall, 1'b0);
        chk("pin_hit_rdata", cpu_rdata, 32'hDEADBEEF);
        access(0, 0, 0, 32'd0, 32'd0, 1);
        @(negedge clock);
        chk("pin_hit_count", hit_count, 32'd1);
        chk("pin_model_hits", exp_hits, 32'd1);

        // Byte store hit merges into lane 1.
        access(0, 1, 1, 32'h41, 32'h0000_00AA, 2);
        access(1, 0, 0, 32'h40, 32'd0, 1);
        @(negedge clock);
        chk("pin_sb_merge", cpu_rdata, 32'hDEADAAEF);

        // Store miss does not allocate; following read misses and fetches it.
        access(0, 1, 0, 32'h80, 32'h1234_5678, 2);
        access(1, 0, 0, 32'h80, 32'd0, 2);
        @(negedge clock);
        chk("pin_nwa_rdata", cpu_rdata, 32'h1234_5678);
        chk("pin_nwa_miss", miss_count, 32'd2);

        // Reset in the middle of a read miss; a late acknowledge is ignored.
        lat = 3;
        cyc();
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_sb = 1'b0; cpu_addr = 32'hC0;
        exp_stall = 1'b1; exp_req = 1'b0; pend_miss = 1;
        cyc();
        exp_req = 1'b1; exp_we = 1'b0; exp_sb = 1'b0; exp_addr = 32'hC0;
        cyc();
        reset = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_rdata = 32'd0;
        exp_hits = 32'd0; exp_misses = 32'd0;
        for (int i = 0; i < 16; i++) mdl_ok[i] = 0;
        @(negedge clock);
        chk("pin_rst_mem_req", mem_req, 1'b0);
        chk("pin_rst_mem_we", mem_we, 1'b0);
        chk("pin_rst_miss", miss_count, 32'd0);
        cyc();
        cyc();
        reset = 1'b1; cpu_read = 1'b0;
        force_data = 32'h0BAD_F00D; force_ready = 1;
        cyc();
        force_ready = 0;
        cyc();
        @(negedge clock);
        chk("pin_late_ready_rdata", cpu_rdata, 32'd0);

        // Conflict on index 0 from zeroed counters.
        access(1, 0, 0, 32'h40, 32'd0, 1);
        access(1, 0, 0, 32'h80, 32'd0, 2);
        access(1, 0, 0, 32'h40, 32'd0, 4);
        @(negedge clock);
        chk("pin_conflict_miss", miss_count, 32'd3);
        chk("pin_conflict_rdata", cpu_rdata, 32'hDEADAAEF);

        // Randomized mix of loads, stores, simultaneous requests and idles.
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0:       tg = 26'd0;
                1:       tg = 26'd1;
                2:       tg = 26'h3FF_FFFF;
                default: tg = 26'h2AA_AAAA;
            endcase
            ra   = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            kind = int'($urandom_range(0, 9));
            if (kind <= 3)
                access(1, 0, 1'($urandom_range(0, 1)), ra, $urandom, int'($urandom_range(1, 4)));
            else if (kind <= 5)
                access(0, 1, 0, ra, $urandom, int'($urandom_range(1, 4)));
            else if (kind <= 7)
                access(0, 1, 1, ra, $urandom, int'($urandom_range(1, 4)));
            else if (kind == 8)
                access(1, 1, 1'($urandom_range(0, 1)), ra, $urandom, int'($urandom_range(1, 4)));
            else
                access(0, 0, 0, ra, 32'd0, 1);
        end
        access(0, 0, 0, 32'd0, 32'd0, 1);
        cyc();
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
